// File: rtl/pot_digitizer.sv
// Paddle RC-timing digitizer: repeating DUMP/COUNT cycle on the phi2 enable turns two 8-bit
// paddle targets into double-buffered POTX/POTY readings.
module pot_digitizer #(
   parameter int DUMP_LEN   = 256,
   parameter int POT_OFFSET = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            ce,
   input  logic [1:0][7:0] pot_in,
   input  logic [1:0]      pot_conn,
   input  logic            rd_sel,
   output logic [7:0]      rd_data,
   output logic [1:0][7:0] pot_reg,
   output logic            dump,
   output logic            sample_done
);
   // state   | meaning
   // S_DUMP  | capacitors held discharged for DUMP_LEN ce ticks
   // S_COUNT | 256 ce ticks, each port latches the count where it crosses its target
   typedef enum logic {S_DUMP, S_COUNT} state_t;

   localparam logic [8:0] LAST_DUMP = 9'(DUMP_LEN - 1);
   localparam logic [8:0] OFFSET9   = 9'(POT_OFFSET);

   state_t          state_q, state_d;
   logic [8:0]      cnt_q, cnt_d;
   logic [1:0][7:0] tgt_q, tgt_d;
   logic [1:0][7:0] acc_q, acc_d;
   logic [1:0]      crossed_q, crossed_d;
   logic [1:0][7:0] pot_reg_q, pot_reg_d;
   logic            sample_done_q, sample_done_d;
   logic            dump_q, dump_d;
   logic [8:0]      sum;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tgt_d         = tgt_q;
      acc_d         = acc_q;
      crossed_d     = crossed_q;
      pot_reg_d     = pot_reg_q;
      sample_done_d = 1'b0;
      sum           = '0;
      if (ce) begin
         case (state_q)
            S_DUMP: begin
               if (cnt_q == LAST_DUMP) begin
                  cnt_d     = '0;
                  state_d   = S_COUNT;
                  crossed_d = '0;
                  acc_d     = '0;
                  for (int i = 0; i < 2; i++) begin
                     sum = {1'b0, pot_in[i]} + OFFSET9;
                     if (!pot_conn[i] || sum[8]) tgt_d[i] = 8'hFF;
                     else                        tgt_d[i] = sum[7:0];
                  end
               end else begin
                  cnt_d = cnt_q + 9'd1;
               end
            end
            S_COUNT: begin
               for (int i = 0; i < 2; i++) begin
                  if (!crossed_q[i] && (cnt_q[7:0] >= tgt_q[i])) begin
                     acc_d[i]     = cnt_q[7:0];
                     crossed_d[i] = 1'b1;
                  end
               end
               if (cnt_q[7:0] == 8'hFF) begin
                  // The crossing found on this last tick must make it into the published reading.
                  for (int i = 0; i < 2; i++)
                     pot_reg_d[i] = crossed_d[i] ? acc_d[i] : 8'hFF;
                  sample_done_d = 1'b1;
                  cnt_d         = '0;
                  state_d       = S_DUMP;
               end else begin
                  cnt_d = cnt_q + 9'd1;
               end
            end
            default: state_d = S_DUMP;
         endcase
      end
      dump_d = (state_d == S_DUMP);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_DUMP;
         cnt_q         <= '0;
         tgt_q         <= '0;
         acc_q         <= '0;
         crossed_q     <= '0;
         pot_reg_q     <= {8'hFF, 8'hFF};
         sample_done_q <= 1'b0;
         dump_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tgt_q         <= tgt_d;
         acc_q         <= acc_d;
         crossed_q     <= crossed_d;
         pot_reg_q     <= pot_reg_d;
         sample_done_q <= sample_done_d;
         dump_q        <= dump_d;
      end
   end

   assign pot_reg     = pot_reg_q;
   assign rd_data     = pot_reg_q[rd_sel];
   assign dump        = dump_q;
   assign sample_done = sample_done_q;
endmodule
